// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Decoupled instruction-fetch front end. Owns the fetch PC, issues
//            in-order requests to an instruction memory of arbitrary latency,
//            buffers returned words with their PCs in a small FIFO and hands
//            them to decode over valid/ready. A redirect flushes the buffer
//            and discards every response still in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN        PC / address width
//   RESET_PC    first fetch address after reset (bits [1:0] must be 0)
//   IBUF_DEPTH  instruction buffer entries (power of two, >= 2)
// Ports
//   clk                clock, rising edge
//   rst                asynchronous active-high reset
//   o_imem_req_valid   fetch request valid
//   i_imem_req_ready   memory accepts the request this cycle
//   o_imem_req_addr    fetch address
//   i_imem_rsp_valid   response valid (in order, at most one per cycle)
//   i_imem_rsp_data    returned instruction word
//   i_redirect_valid   one-cycle pulse: restart fetch at i_redirect_pc
//   i_redirect_pc      new fetch PC, bits [1:0] ignored
//   o_inst_valid       buffer head valid
//   i_inst_ready       decode consumes the head
//   o_inst_data        head instruction word
//   o_inst_pc          PC of the head instruction
// ============================================================================
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IBUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [31:0]     i_imem_rsp_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [31:0]     o_inst_data,
  output logic [XLEN-1:0] o_inst_pc
);

  localparam int                 c_PTR_W      = $clog2(IBUF_DEPTH);
  localparam int                 c_CNT_W      = $clog2(IBUF_DEPTH + 1);
  localparam logic [c_CNT_W:0]   c_CREDIT_MAX = (c_CNT_W + 1)'(IBUF_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
  localparam logic [XLEN-1:0]    c_PC_STEP    = XLEN'(4);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]    r_fetch_pc;
  logic [c_CNT_W-1:0] r_inflight;   // accepted requests not yet answered
  logic [c_CNT_W-1:0] r_discard;    // answers still owed to a stale stream
  logic [c_CNT_W-1:0] r_count;      // instruction buffer occupancy
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_sh_rd_ptr;  // shadow PC queue, one entry per in-flight
  logic [c_PTR_W-1:0] r_sh_wr_ptr;

  logic [XLEN-1:0]    r_fifo_pc   [IBUF_DEPTH];
  logic [31:0]        r_fifo_data [IBUF_DEPTH];
  logic [XLEN-1:0]    r_shadow_pc [IBUF_DEPTH];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [c_CNT_W:0]   w_credit_sum;
  logic               w_req_valid;
  logic               w_accept;
  logic               w_rsp;
  logic               w_drop;
  logic               w_push;
  logic               w_inst_valid;
  logic               w_pop;
  logic [XLEN-1:0]    w_redirect_pc;
  logic [XLEN-1:0]    w_rsp_pc;
  logic               w_unused_redirect_lsb;

  logic [XLEN-1:0]    w_fetch_pc_nxt;
  logic [c_CNT_W-1:0] w_inflight_nxt;
  logic [c_CNT_W-1:0] w_discard_nxt;
  logic [c_CNT_W-1:0] w_count_nxt;
  logic [c_PTR_W-1:0] w_rd_ptr_nxt;
  logic [c_PTR_W-1:0] w_wr_ptr_nxt;
  logic [c_PTR_W-1:0] w_sh_rd_ptr_nxt;
  logic [c_PTR_W-1:0] w_sh_wr_ptr_nxt;

  assign w_redirect_pc         = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_redirect_lsb = ^i_redirect_pc[1:0];

  // Credit covers both the buffered words and every word still owed by
  // memory, so a response always finds a free buffer slot. Discarded
  // responses also hold credit until they arrive, which keeps the shadow
  // PC queue from ever overflowing.
  assign w_credit_sum = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_req_valid  = !rst && !i_redirect_valid && (w_credit_sum < c_CREDIT_MAX);
  assign w_accept     = w_req_valid && i_imem_req_ready;

  // A response with nothing in flight is a protocol violation: ignore it.
  assign w_rsp  = i_imem_rsp_valid && (r_inflight != '0);
  assign w_drop = w_rsp && (r_discard != '0);
  // During a redirect the arriving response belongs to the old stream even
  // when the discard counter is still zero.
  assign w_push = w_rsp && !w_drop && !i_redirect_valid;

  assign w_inst_valid = (r_count != '0);
  assign w_pop        = w_inst_valid && i_inst_ready;
  assign w_rsp_pc     = r_shadow_pc[r_sh_rd_ptr];

  always_comb begin
    w_fetch_pc_nxt  = r_fetch_pc;
    w_inflight_nxt  = r_inflight;
    w_discard_nxt   = r_discard;
    w_count_nxt     = r_count;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_sh_rd_ptr_nxt = r_sh_rd_ptr;
    w_sh_wr_ptr_nxt = r_sh_wr_ptr;

    if (w_accept && !w_rsp) begin
      w_inflight_nxt = r_inflight + c_CNT_ONE;
    end else if (!w_accept && w_rsp) begin
      w_inflight_nxt = r_inflight - c_CNT_ONE;
    end

    // The shadow queue tracks every accepted request, discarded or not, so
    // it stays aligned with the memory's in-order response stream.
    if (w_accept) begin
      w_sh_wr_ptr_nxt = r_sh_wr_ptr + c_PTR_ONE;
    end
    if (w_rsp) begin
      w_sh_rd_ptr_nxt = r_sh_rd_ptr + c_PTR_ONE;
    end

    if (i_redirect_valid) begin
      // No request is accepted this cycle, so the post-response in-flight
      // count is exactly what is still owed by the stale stream. This also
      // accumulates correctly across back-to-back redirects.
      w_fetch_pc_nxt = w_redirect_pc;
      w_discard_nxt  = w_inflight_nxt;
      w_count_nxt    = '0;
      w_rd_ptr_nxt   = '0;
      w_wr_ptr_nxt   = '0;
    end else begin
      if (w_accept) begin
        w_fetch_pc_nxt = r_fetch_pc + c_PC_STEP;
      end
      if (w_drop) begin
        w_discard_nxt = r_discard - c_CNT_ONE;
      end
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        w_count_nxt = r_count + c_CNT_ONE;
      end else if (!w_push && w_pop) begin
        w_count_nxt = r_count - c_CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_inflight  <= '0;
      r_discard   <= '0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_sh_rd_ptr <= '0;
      r_sh_wr_ptr <= '0;
    end else begin
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_inflight  <= w_inflight_nxt;
      r_discard   <= w_discard_nxt;
      r_count     <= w_count_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_sh_rd_ptr <= w_sh_rd_ptr_nxt;
      r_sh_wr_ptr <= w_sh_wr_ptr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Storage arrays: contents are only observed through valid occupancy, so
  // they carry no reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shadow_pc[r_sh_wr_ptr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= w_rsp_pc;
      r_fifo_data[r_wr_ptr] <= i_imem_rsp_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decode sees only registered buffer state, never imem_rsp_*.
  // Head fields are forced to zero while the buffer is empty.
  // --------------------------------------------------------------------------
  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = r_fetch_pc;
  assign o_inst_valid     = w_inst_valid;
  assign o_inst_data      = w_inst_valid ? r_fifo_data[r_rd_ptr] : 32'd0;
  assign o_inst_pc        = w_inst_valid ? r_fifo_pc[r_rd_ptr]   : '0;

endmodule
`default_nettype wire
